// File: rtl/cpu_pkg.sv
// Shared CPU-wide sizing defaults for the register file and its scoreboard.
package cpu_pkg;

    localparam int unsigned DW_DEFAULT   = 32;
    localparam int unsigned AW_DEFAULT   = 5;
    localparam int unsigned NREG_DEFAULT = 1 << AW_DEFAULT;

    // Number of architectural registers addressable with an aw-bit select.
    function automatic int unsigned nreg_of(input int unsigned aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: set on issue, cleared on write-back, issue wins ties.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic          busy_a,
    output logic          busy_b
);

    localparam int unsigned NREG = nreg_of(AW);

    // busy[0] is never set, so r0 can never report an outstanding producer.
    logic [NREG-1:0] busy;
    logic            wr_valid;
    logic            iss_valid;

    assign wr_valid  = we && (waddr != '0);
    assign iss_valid = issue_en && (issue_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_valid) begin
                busy[waddr] <= 1'b0;
            end
            // Later assignment wins: a same-cycle newer producer keeps the bit set.
            if (iss_valid) begin
                busy[issue_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        if (rst_n) begin
            busy_a = busy[raddr_a] && !(we && (waddr == raddr_a));
            busy_b = busy[raddr_b] && !(we && (waddr == raddr_b));
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with write bypass and a busy scoreboard.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_addr,
    output logic          busy_a,
    output logic          busy_b,
    output logic          stall
);

    localparam int unsigned NREG = nreg_of(AW);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 reads as zero; a same-cycle write to the read address is forwarded.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (rst_n) begin
            if (raddr_a != '0) begin
                rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
            end
            if (raddr_b != '0) begin
                rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
            end
        end
    end

    reg_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .we         (we),
        .waddr      (waddr),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );

    assign stall = busy_a | busy_b;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb: storage, bypass, busy and reset.
module tb_reg_file_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          issue_en;
    logic [AW-1:0] issue_addr;
    logic          busy_a;
    logic          busy_b;
    logic          stall;

    int unsigned errors;
    int unsigned checks;

    reg_file_sb #(
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .stall      (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        we         = 1'b1;
        waddr      = 5'd5;
        wdata      = 32'hFFFF_FFFF;
        issue_en   = 1'b1;
        issue_addr = 5'd5;
        raddr_a    = 5'd5;
        raddr_b    = 5'd5;
        #2;
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata_hold: a=%h b=%h, expected 0", rdata_a, rdata_b);
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_hold: busy_a=%b busy_b=%b stall=%b, expected 0", busy_a, busy_b, stall);
        end
        step();
        step();
        idle();
        #2;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #1;
            checks++;
            if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL reset_read[%0d]: a=%h b=%h, expected 0", i, rdata_a, rdata_b);
            end
            checks++;
            if (busy_a !== 1'b0 || busy_b !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy[%0d]: busy_a=%b busy_b=%b stall=%b, expected 0", i, busy_a, busy_b, stall);
            end
        end
        step();
    endtask

    task automatic test_write_read();
        we      = 1'b1;
        waddr   = 5'd5;
        wdata   = 32'hDEAD_BEEF;
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        step();
        idle();
        raddr_a = 5'd5;
        #1;
        checks++;
        if (rdata_a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_read_r5: rdata_a=%h, expected deadbeef", rdata_a);
        end
        we      = 1'b1;
        waddr   = 5'd0;
        wdata   = 32'h1234_5678;
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        #1;
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL r0_no_bypass: a=%h b=%h, expected 0", rdata_a, rdata_b);
        end
        step();
        idle();
        #1;
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL r0_write_ignored: rdata_a=%h, expected 0", rdata_a);
        end
    endtask

    task automatic test_bypass();
        raddr_a = 5'd5;
        raddr_b = 5'd7;
        #1;
        checks++;
        if (rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL bypass_pre: rdata_b=%h, expected 0", rdata_b);
        end
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (rdata_b !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL bypass_same_cycle: rdata_b=%h, expected a5a5a5a5", rdata_b);
        end
        checks++;
        if (rdata_a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_other_port: rdata_a=%h, expected deadbeef", rdata_a);
        end
        step();
        idle();
        #1;
        checks++;
        if (rdata_b !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL bypass_stored: rdata_b=%h, expected a5a5a5a5", rdata_b);
        end
    endtask

    task automatic test_busy();
        raddr_a    = 5'd9;
        raddr_b    = 5'd0;
        issue_en   = 1'b1;
        issue_addr = 5'd9;
        #1;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_before_edge: busy_a=%b, expected 0", busy_a);
        end
        step();
        idle();
        #1;
        checks++;
        if (busy_a !== 1'b1 || stall !== 1'b1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL busy_set: busy_a=%b busy_b=%b stall=%b, expected 1 0 1", busy_a, busy_b, stall);
        end
        raddr_b = 5'd9;
        #1;
        checks++;
        if (busy_b !== 1'b1) begin
            errors++;
            $display("FAIL busy_port_b: busy_b=%b, expected 1", busy_b);
        end
        raddr_b = 5'd0;
        step();
        we    = 1'b1;
        waddr = 5'd9;
        wdata = 32'h55;
        #1;
        checks++;
        if (busy_a !== 1'b0 || stall !== 1'b0 || rdata_a !== 32'h55) begin
            errors++;
            $display("FAIL busy_writeback: busy_a=%b stall=%b rdata_a=%h, expected 0 0 55", busy_a, stall, rdata_a);
        end
        step();
        idle();
        #1;
        checks++;
        if (busy_a !== 1'b0 || rdata_a !== 32'h55) begin
            errors++;
            $display("FAIL busy_cleared: busy_a=%b rdata_a=%h, expected 0 55", busy_a, rdata_a);
        end
    endtask

    task automatic test_issue_wins();
        raddr_a    = 5'd3;
        raddr_b    = 5'd0;
        issue_en   = 1'b1;
        issue_addr = 5'd3;
        step();
        idle();
        #1;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL issue_r3: busy_a=%b, expected 1", busy_a);
        end
        issue_en   = 1'b1;
        issue_addr = 5'd3;
        we         = 1'b1;
        waddr      = 5'd3;
        wdata      = 32'h1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || rdata_a !== 32'h1) begin
            errors++;
            $display("FAIL tie_same_cycle: busy_a=%b rdata_a=%h, expected 0 1", busy_a, rdata_a);
        end
        step();
        idle();
        #1;
        checks++;
        if (busy_a !== 1'b1 || stall !== 1'b1 || rdata_a !== 32'h1) begin
            errors++;
            $display("FAIL tie_issue_wins: busy_a=%b stall=%b rdata_a=%h, expected 1 1 1", busy_a, stall, rdata_a);
        end
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'h2;
        step();
        idle();
        #1;
        checks++;
        if (busy_a !== 1'b0 || rdata_a !== 32'h2) begin
            errors++;
            $display("FAIL tie_drain: busy_a=%b rdata_a=%h, expected 0 2", busy_a, rdata_a);
        end
    endtask

    task automatic test_reissue_and_plain_write();
        raddr_a    = 5'd10;
        raddr_b    = 5'd11;
        issue_en   = 1'b1;
        issue_addr = 5'd10;
        step();
        step();
        idle();
        #1;
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reissue_busy: busy_a=%b busy_b=%b, expected 1 0", busy_a, busy_b);
        end
        we    = 1'b1;
        waddr = 5'd11;
        wdata = 32'hCAFE_0011;
        step();
        we    = 1'b1;
        waddr = 5'd10;
        wdata = 32'hCAFE_0010;
        step();
        idle();
        #1;
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reissue_single_clear: busy_a=%b busy_b=%b stall=%b, expected 0", busy_a, busy_b, stall);
        end
        checks++;
        if (rdata_a !== 32'hCAFE_0010 || rdata_b !== 32'hCAFE_0011) begin
            errors++;
            $display("FAIL plain_write_data: a=%h b=%h, expected cafe0010 cafe0011", rdata_a, rdata_b);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            we         = 1'b1;
            waddr      = 5'(i + 15);
            wdata      = 32'h1000_0000 + 32'(i);
            issue_en   = 1'b1;
            issue_addr = 5'(i + 19);
            step();
        end
        idle();
        for (int i = 1; i <= 4; i++) begin
            raddr_a = 5'(i + 15);
            raddr_b = 5'(i + 19);
            #1;
            checks++;
            if (rdata_a !== 32'h1000_0000 + 32'(i) || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL b2b_data[%0d]: rdata_a=%h busy_a=%b, expected %h 0", i, rdata_a, busy_a, 32'h1000_0000 + 32'(i));
            end
            checks++;
            if (busy_b !== 1'b1 || rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL b2b_busy[%0d]: busy_b=%b rdata_b=%h, expected 1 0", i, busy_b, rdata_b);
            end
        end
    endtask

    task automatic test_async_reset();
        we      = 1'b1;
        waddr   = 5'd4;
        wdata   = 32'h99;
        step();
        idle();
        issue_en   = 1'b1;
        issue_addr = 5'd4;
        step();
        issue_addr = 5'd6;
        step();
        idle();
        raddr_a = 5'd4;
        raddr_b = 5'd6;
        #1;
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1 || rdata_a !== 32'h99) begin
            errors++;
            $display("FAIL areset_pre: busy_a=%b busy_b=%b rdata_a=%h, expected 1 1 99", busy_a, busy_b, rdata_a);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata_a !== 32'h0 || busy_a !== 1'b0 || busy_b !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: rdata_a=%h busy_a=%b busy_b=%b stall=%b, expected 0", rdata_a, busy_a, busy_b, stall);
        end
        step();
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdata_a !== 32'h0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL areset_release: rdata_a=%h busy_a=%b busy_b=%b, expected 0", rdata_a, busy_a, busy_b);
        end
        step();
        checks++;
        if (rdata_a !== 32'h0 || busy_a !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL areset_after_edge: rdata_a=%h busy_a=%b stall=%b, expected 0", rdata_a, busy_a, stall);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle();
        raddr_a = '0;
        raddr_b = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_busy();
        test_issue_wins();
        test_reissue_and_plain_write();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
- REQ-001: Parameter DW, default 32, data word width.
- REQ-002: Parameter AW, default 5, register address width; register count is 2^AW.
- REQ-003: The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
- REQ-004: clk  input  1  rising-edge clock for all state.
- REQ-005: rst_n  input  1  asynchronous active-low reset.
- REQ-006: we  input  1  write-back enable.
- REQ-007: waddr  input  AW  write-back destination address (the 5-bit rt/rd select result).
- REQ-008: wdata  input  DW  write-back data.
- REQ-009: raddr_a, raddr_b  input  AW each  read port addresses.
- REQ-010: rdata_a, rdata_b  output  DW each  read data, combinational.
- REQ-011: issue_en  input  1  an instruction is issued that will later write issue_addr.
- REQ-012: issue_addr  input  AW  destination of the issued instruction.
- REQ-013: busy_a, busy_b  output  1 each  the read operand has an outstanding producer.
- REQ-014: stall  output  1  busy_a OR busy_b.

Function
- REQ-015: Storage SHALL be 2^AW registers of DW bits, written on the rising clk edge when we=1 and waddr!=0.
- REQ-016: Register 0 SHALL always read 0, ignore writes, and never be busy.
- REQ-017: Reads SHALL be zero-latency combinational.
- REQ-018: Write bypass: when we=1, waddr==raddr_x, and raddr_x!=0, rdata_x SHALL equal wdata in the same cycle.
- REQ-019: Each register 1..2^AW-1 SHALL have one busy bit.
- REQ-020: issue_en=1 with issue_addr!=0 SHALL set busy[issue_addr] at the clock edge.
- REQ-021: we=1 with waddr!=0 SHALL clear busy[waddr] at the clock edge.
- REQ-022: If issue and write target the same address in the same cycle, issue SHALL win and the busy bit SHALL remain set, because the newer producer is outstanding.
- REQ-023: busy_x SHALL equal busy[raddr_x] AND NOT (we AND waddr==raddr_x), so that bypassed data is not stalled.
- REQ-024: issue_en to an already-busy register SHALL leave its busy bit set; no counter or overflow applies.
- REQ-025: we to a non-busy register SHALL update data normally; the busy bit stays clear.
- REQ-026: stall SHALL be purely combinational from busy_a and busy_b, with no registered delay.

Reset
- REQ-027: rst_n=0 SHALL asynchronously clear all registers and all busy bits.
- REQ-028: While rst_n=0, rdata_a=rdata_b=0 and busy_a=busy_b=stall=0 regardless of other inputs, and writes and issues SHALL be ignored.
- REQ-029: Reset asserted mid-operation SHALL discard outstanding busy state; the first edge after deassertion behaves as from a clean state.

Structure
- REQ-030: DW, AW, and NREG=2^AW defaults SHALL live in a shared package, cpu_pkg.
- REQ-031: Busy tracking SHALL be a sub-module reg_scoreboard, with ports clk, rst_n, issue_en, issue_addr, we, waddr, raddr_a, raddr_b, busy_a, and busy_b.
- REQ-032: Data storage and bypass SHALL reside in reg_file_sb.

Verification
- REQ-033: Reset, then read all 32 addresses: rdata=0, busy=0, stall=0.
- REQ-034: Write 0xDEADBEEF to r5, next cycle read r5 on port a: rdata_a=0xDEADBEEF; write 0x12345678 to r0, then read r0: 0.
- REQ-035: Same-cycle we=1, waddr=7, wdata=0xA5A5A5A5, raddr_b=7: rdata_b=0xA5A5A5A5 before the edge.
- REQ-036: Issue r9, then read r9 next cycle: busy_a=1, stall=1; write-back r9 with 0x55: busy_a drops in the write cycle, rdata_a=0x55, and busy stays 0 afterwards.
- REQ-037: Busy r3 outstanding, then in one cycle issue r3 and write r3=0x1: next cycle busy[r3]=1 and data=0x1.
- REQ-038: Set r4, r6 busy with r4 holding 0x99; assert rst_n=0 asynchronously between edges: outputs drop to 0 immediately, and after release r4 reads 0 and is not busy.
